// File: rtl/int32_to_ascii.sv
// int32_to_ascii
//   Converts a signed 32-bit integer into an ASCII byte stream: an optional
//   '-', then the decimal digits MSB-first with no leading zeros, then an
//   optional separator. Values arrive on a valid/ready handshake. Bytes leave
//   on a second valid/ready handshake, with char_last marking the final byte.
//
//   Ports:
//     clk, rst                  rising-edge clock, async active-high reset
//     value_in/valid/ready      input value handshake (ready only in IDLE)
//     char_out/valid/ready      output byte handshake
//     char_last                 final byte of the current number
//
//   Digits are produced LS-first by repeated divide-by-10, one per cycle,
//   into a 10-entry nibble buffer. That buffer is then read back
//   top-down. Every output is decoded from registered state only.
module int32_to_ascii #(
  parameter bit          SEP_EN   = 1'b1,
  parameter logic [7:0]  SEP_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_last
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_SIGN  = 3'd2;
  localparam logic [2:0] S_DIGIT = 3'd3;
  localparam logic [2:0] S_SEP   = 3'd4;

  logic [2:0]  state;
  logic        neg;
  logic [31:0] mag;
  logic [3:0]  cnt;
  logic [3:0]  dig_buf [0:9];

  logic [31:0] quo;
  logic [3:0]  quo_lo10;
  logic [3:0]  rem4;
  logic [31:0] abs_in;

  // The remainder is always < 10, so it can be recovered from the low nibble
  // alone: mag - 10*quo taken modulo 16.
  assign quo      = mag / 32'd10;
  assign quo_lo10 = quo[3:0] * 4'd10;
  assign rem4     = mag[3:0] - quo_lo10;

  // Unsigned magnitude. 0x80000000 maps to itself, which is the correct
  // magnitude 2147483648 when read as unsigned.
  assign abs_in = value_in[31] ? (~value_in + 32'd1) : value_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      neg   <= 1'b0;
      mag   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (value_valid) begin
          neg   <= value_in[31];
          mag   <= abs_in;
          cnt   <= '0;
          state <= S_CONV;
        end
        S_CONV: begin
          mag <= quo;
          cnt <= cnt + 4'd1;
          if (quo == 32'd0) state <= neg ? S_SIGN : S_DIGIT;
        end
        S_SIGN: if (char_ready) state <= S_DIGIT;
        S_DIGIT: if (char_ready) begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= SEP_EN ? S_SEP : S_IDLE;
        end
        S_SEP: if (char_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Digit storage needs no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    if (state == S_CONV) dig_buf[cnt] <= rem4;
  end

  assign value_ready = (state == S_IDLE);
  assign char_valid  = (state == S_SIGN) || (state == S_DIGIT) || (state == S_SEP);
  assign char_last   = (state == S_SEP) ||
                       (!SEP_EN && (state == S_DIGIT) && (cnt == 4'd1));

  always_comb begin
    char_out = 8'h00;
    case (state)
      S_SIGN:  char_out = 8'h2D;
      S_DIGIT: char_out = 8'h30 + {4'h0, dig_buf[cnt - 4'd1]};
      S_SEP:   char_out = SEP_CHAR;
      default: char_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_int32_to_ascii.sv
module tb_int32_to_ascii;

  logic        clk, rst;
  logic [31:0] value_in;
  logic        value_valid, char_ready;
  logic        value_ready, char_valid, char_last;
  logic [7:0]  char_out;
  logic        value_ready0, char_valid0, char_last0;
  logic [7:0]  char_out0;

  int nchk = 0;
  int nfail = 0;

  // Capture buffers: b1/k1 from the separator instance, b0/k0 from the
  // no-separator instance. Both instances see identical inputs.
  logic [7:0] b1 [0:15];
  logic       k1 [0:15];
  logic [7:0] b0 [0:15];
  logic       k0 [0:15];
  int n1, n0, first;
  bit tmo;

  int32_to_ascii #(.SEP_EN(1'b1), .SEP_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .char_last(char_last));

  int32_to_ascii #(.SEP_EN(1'b0), .SEP_CHAR(8'h20)) dut0 (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready0), .char_out(char_out0), .char_valid(char_valid0),
    .char_ready(char_ready), .char_last(char_last0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with both instances idle. Sends v with char_ready
  // held high and records every transfer until the separator instance's
  // last byte. Returns at the negedge after that last transfer.
  // first = cycle (accept edge = 0) of the first char_valid.
  task automatic collect(input logic [31:0] v);
    int cyc;
    bit done;
    n1 = 0; n0 = 0; first = -1; tmo = 1'b0; done = 1'b0;
    value_in = v; value_valid = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (char_valid && first < 0) first = cyc;
      if (char_valid0 && n0 < 16) begin b0[n0] = char_out0; k0[n0] = char_last0; n0++; end
      if (char_valid && n1 < 16) begin
        b1[n1] = char_out; k1[n1] = char_last; n1++;
        if (char_last) done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    nchk++; if (char_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", char_valid); end
    nchk++; if (char_last !== 1'b0) begin nfail++; $display("FAIL reset_last got %b want 0", char_last); end
    nchk++; if (char_out !== 8'h00) begin nfail++; $display("FAIL reset_out got %h want 00", char_out); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchk++; if (value_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b want 1", value_ready); end
    nchk++; if (char_valid0 !== 1'b0) begin nfail++; $display("FAIL reset_valid0 got %b want 0", char_valid0); end
  endtask

  task automatic test_zero;
    collect(32'd0);
    nchk++; if (tmo !== 1'b0) begin nfail++; $display("FAIL zero_timeout got %b want 0", tmo); end
    nchk++; if (n1 !== 2) begin nfail++; $display("FAIL zero_count got %0d want 2", n1); end
    nchk++; if (b1[0] !== 8'h30 || k1[0] !== 1'b0) begin nfail++; $display("FAIL zero_b0 got %h/%b want 30/0", b1[0], k1[0]); end
    nchk++; if (b1[1] !== 8'h20 || k1[1] !== 1'b1) begin nfail++; $display("FAIL zero_b1 got %h/%b want 20/1", b1[1], k1[1]); end
    nchk++; if (first !== 2) begin nfail++; $display("FAIL zero_latency got %0d want 2", first); end
    nchk++; if (n0 !== 1 || b0[0] !== 8'h30 || k0[0] !== 1'b1) begin nfail++; $display("FAIL zero_nosep got n=%0d %h/%b want 1 30/1", n0, b0[0], k0[0]); end
  endtask

  task automatic test_multi_digit;
    string e;
    e = "12345 ";
    collect(32'd12345);
    nchk++; if (n1 !== 6 || tmo) begin nfail++; $display("FAIL d12345_count got %0d want 6", n1); end
    nchk++; if (first !== 6) begin nfail++; $display("FAIL d12345_convert got first=%0d want 6", first); end
    for (int i = 0; i < 6; i++) begin
      nchk++;
      if (b1[i] !== e.getc(i) || k1[i] !== (i == 5))
        begin nfail++; $display("FAIL d12345_byte%0d got %h/%b want %h/%b", i, b1[i], k1[i], e.getc(i), (i == 5)); end
    end
  endtask

  task automatic test_negative;
    collect(-32'd7);
    nchk++; if (n1 !== 3 || first !== 2) begin nfail++; $display("FAIL neg7_count got n=%0d first=%0d want 3/2", n1, first); end
    nchk++; if (b1[0] !== 8'h2D || b1[1] !== 8'h37 || b1[2] !== 8'h20) begin nfail++; $display("FAIL neg7_bytes got %h %h %h want 2d 37 20", b1[0], b1[1], b1[2]); end
    nchk++; if (k1[0] | k1[1] | !k1[2]) begin nfail++; $display("FAIL neg7_last got %b%b%b want 001", k1[0], k1[1], k1[2]); end
    nchk++; if (n0 !== 2 || b0[0] !== 8'h2D || b0[1] !== 8'h37) begin nfail++; $display("FAIL neg7_nosep got n=%0d %h %h want 2 2d 37", n0, b0[0], b0[1]); end
    nchk++; if (k0[0] !== 1'b0 || k0[1] !== 1'b1) begin nfail++; $display("FAIL neg7_nosep_last got %b%b want 01", k0[0], k0[1]); end
  endtask

  // Extremes, sent back-to-back: the second value goes in on the very
  // cycle value_ready returns.
  task automatic test_back_to_back;
    string e;
    e = "-2147483648 ";
    collect(32'h8000_0000);
    nchk++; if (n1 !== 12 || first !== 11) begin nfail++; $display("FAIL min_count got n=%0d first=%0d want 12/11", n1, first); end
    for (int i = 0; i < 12; i++) begin
      nchk++;
      if (b1[i] !== e.getc(i) || k1[i] !== (i == 11))
        begin nfail++; $display("FAIL min_byte%0d got %h/%b want %h", i, b1[i], k1[i], e.getc(i)); end
    end
    nchk++; if (value_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready got %b want 1", value_ready); end
    e = "2147483647 ";
    collect(32'h7FFF_FFFF);
    nchk++; if (n1 !== 11 || first !== 11) begin nfail++; $display("FAIL max_count got n=%0d first=%0d want 11/11", n1, first); end
    for (int i = 0; i < 11; i++) begin
      nchk++;
      if (b1[i] !== e.getc(i) || k1[i] !== (i == 10))
        begin nfail++; $display("FAIL max_byte%0d got %h/%b want %h", i, b1[i], k1[i], e.getc(i)); end
    end
  endtask

  task automatic test_stall;
    string e;
    logic [7:0] po;
    logic pl;
    bit pv, done;
    int n, stall3, cyc;
    e = "-305 ";
    n = 0; stall3 = 0; pv = 1'b0; done = 1'b0; po = 8'h00; pl = 1'b0;
    value_in = -32'd305; value_valid = 1'b1; char_ready = 1'b0;
    @(negedge clk);
    value_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (pv) begin
        nchk++;
        if (char_valid !== 1'b1 || char_out !== po || char_last !== pl)
          begin nfail++; $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", char_valid, char_out, char_last, po, pl); end
      end
      if (char_valid && char_out == 8'h33 && stall3 < 5) begin char_ready = 1'b0; stall3++; end
      else char_ready = 1'($urandom_range(0, 1));
      if (char_valid && char_ready) begin
        if (n < 16) begin b1[n] = char_out; k1[n] = char_last; end
        n++;
        if (char_last) done = 1'b1;
      end
      pv = char_valid && !char_ready; po = char_out; pl = char_last;
      @(negedge clk);
      cyc++;
    end
    char_ready = 1'b1;
    nchk++; if (!done || n !== 5) begin nfail++; $display("FAIL stall_count got n=%0d done=%b want 5/1", n, done); end
    nchk++; if (stall3 !== 5) begin nfail++; $display("FAIL stall_on3 got %0d want 5", stall3); end
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if (b1[i] !== e.getc(i) || k1[i] !== (i == 4))
        begin nfail++; $display("FAIL stall_byte%0d got %h/%b want %h", i, b1[i], k1[i], e.getc(i)); end
    end
    // Let the no-separator instance settle too before the next test.
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, cyc;
    n = 0; cyc = 0;
    value_in = 32'd98765; value_valid = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    while (!(char_valid && n == 2) && cyc < 40) begin
      if (char_valid) n++;
      @(negedge clk);
      cyc++;
    end
    nchk++; if (!(char_valid && n == 2) || char_out !== 8'h37) begin nfail++; $display("FAIL rstmid_third got valid=%b out=%h want 1/37", char_valid, char_out); end
    rst = 1'b1;
    #1;
    nchk++; if (char_valid !== 1'b0 || char_last !== 1'b0) begin nfail++; $display("FAIL rstmid_abort got %b/%b want 0/0", char_valid, char_last); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nchk++; if (value_ready !== 1'b1) begin nfail++; $display("FAIL rstmid_ready got %b want 1", value_ready); end
    @(negedge clk);
    collect(32'd4);
    nchk++; if (n1 !== 2 || tmo) begin nfail++; $display("FAIL rstmid_next_count got %0d want 2", n1); end
    nchk++; if (b1[0] !== 8'h34 || b1[1] !== 8'h20 || k1[1] !== 1'b1) begin nfail++; $display("FAIL rstmid_next got %h %h/%b want 34 20/1", b1[0], b1[1], k1[1]); end
  endtask

  initial begin
    rst = 1'b1; value_in = '0; value_valid = 1'b0; char_ready = 1'b0;
    test_reset;
    test_zero;
    test_multi_digit;
    test_negative;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
